// File: rtl/data_demux_stream.sv
// data_demux_stream: routes one valid/ready input stream to one of two
// output streams by a per-word select. Each output is buffered by its own
// DEPTH-entry FIFO, and each output counts the words it has delivered.
module data_demux_stream #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out0_data,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [WIDTH-1:0]           out1_data,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [$clog2(DEPTH):0]     occ0,
    output logic [$clog2(DEPTH):0]     occ1,
    output logic [15:0]                del0,
    output logic [15:0]                del1
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] FULL_COUNT = OW'(DEPTH);

    // Per-channel status/handshake vectors, index = output number
    logic [1:0]            full;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            valid;
    logic [1:0]            out_ready;
    logic [1:0][WIDTH-1:0] head;
    logic [1:0][OW-1:0]    occ_vec;
    logic [1:0][15:0]      del_vec;
    logic                  accept;

    assign out_ready = {out1_ready, out0_ready};

    // Ready depends only on the selected FIFO's registered occupancy, so a
    // full target stalls the input even if the other FIFO has room and a pop
    // on the full FIFO is happening this cycle.
    assign in_ready = in_sel ? !full[1] : !full[0];
    assign accept   = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [WIDTH-1:0] mem_reg [DEPTH];
            logic [PW-1:0]    wr_ptr_reg;
            logic [PW-1:0]    rd_ptr_reg;
            logic [OW-1:0]    occ_reg;
            logic [OW-1:0]    occ_next;
            logic [15:0]      del_reg;

            assign push[gi]    = accept && (in_sel == 1'(gi));
            assign valid[gi]   = (occ_reg != '0);
            assign pop[gi]     = valid[gi] && out_ready[gi];
            assign full[gi]    = (occ_reg == FULL_COUNT);
            assign head[gi]    = mem_reg[rd_ptr_reg];
            assign occ_vec[gi] = occ_reg;
            assign del_vec[gi] = del_reg;

            // Occupancy: +1 on push only, -1 on pop only, else unchanged
            always_comb begin
                occ_next = occ_reg;
                case ({push[gi], pop[gi]})
                    2'b10:   occ_next = occ_reg + OW'(1);
                    2'b01:   occ_next = occ_reg - OW'(1);
                    default: occ_next = occ_reg;
                endcase
            end

            // Storage: cleared on reset so the head reads 0 afterwards
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                end else if (push[gi]) begin
                    mem_reg[wr_ptr_reg] <= in_data;
                end
            end

            // Pointers, occupancy and delivered-word counter
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    occ_reg    <= '0;
                    del_reg    <= '0;
                end else begin
                    occ_reg <= occ_next;
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                        del_reg    <= del_reg + 16'd1;
                    end
                end
            end
        end
    endgenerate

    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign out0_valid = valid[0];
    assign out1_valid = valid[1];
    assign occ0       = occ_vec[0];
    assign occ1       = occ_vec[1];
    assign del0       = del_vec[0];
    assign del1       = del_vec[1];

endmodule

// File: tb/tb_data_demux_stream.sv
// tb_data_demux_stream: directed stimulus with a queue-based model of the
// two output streams, compared against the DUT on every falling edge, plus
// hand-computed literal expectations at key points.
module tb_data_demux_stream;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [1:0]       occ0;
    logic [1:0]       occ1;
    logic [15:0]      del0;
    logic [15:0]      del1;

    int checks   = 0;
    int failures = 0;

    data_demux_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .occ0       (occ0),
        .occ1       (occ1),
        .del0       (del0),
        .del1       (del1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: one queue per output; delivered counts as plain integers
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [15:0]      m_del0;
    logic [15:0]      m_del1;
    bit               model_on = 0;

    function automatic logic model_ready(input logic sel);
        return sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    endfunction

    // Advance the model at each rising edge using the inputs held there
    always @(posedge clk) begin
        logic acc;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_del0   = 16'd0;
            m_del1   = 16'd0;
            model_on = 1;
        end else if (model_on) begin
            acc = in_valid && model_ready(in_sel);
            if (out0_ready && q0.size() > 0) begin
                void'(q0.pop_front());
                m_del0 = m_del0 + 16'd1;
            end
            if (out1_ready && q1.size() > 0) begin
                void'(q1.pop_front());
                m_del1 = m_del1 + 16'd1;
            end
            if (acc) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_in_ready",   {31'd0, in_ready},   {31'd0, model_ready(in_sel)});
            chk("m_out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
            chk("m_out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
            if (q0.size() != 0) chk("m_out0_data", {16'd0, out0_data}, {16'd0, q0[0]});
            if (q1.size() != 0) chk("m_out1_data", {16'd0, out1_data}, {16'd0, q1[0]});
            chk("m_occ0", {30'd0, occ0}, 32'(q0.size()));
            chk("m_occ1", {30'd0, occ1}, 32'(q1.size()));
            chk("m_del0", {16'd0, del0}, {16'd0, m_del0});
            chk("m_del1", {16'd0, del1}, {16'd0, m_del1});
        end
    end

    task automatic drive(input logic v, input logic s, input logic [15:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 16'h0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        $display("TX reset released");
        chk("rst_occ0",   {30'd0, occ0}, 32'd0);
        chk("rst_valid0", {31'd0, out0_valid}, 32'd0);
        chk("rst_data0",  {16'd0, out0_data}, 32'd0);
        chk("rst_del1",   {16'd0, del1}, 32'd0);

        // Single word to output 0
        drive(1, 0, 16'h1234, 0, 0);
        $display("TX push sel=0 data=1234");
        step();
        drive(0, 0, 16'h0, 0, 0);
        chk("t1_valid0", {31'd0, out0_valid}, 32'd1);
        chk("t1_data0",  {16'd0, out0_data}, 32'h1234);
        chk("t1_occ0",   {30'd0, occ0}, 32'd1);
        chk("t1_valid1", {31'd0, out1_valid}, 32'd0);
        drive(0, 0, 16'h0, 1, 0);
        step();
        $display("TX pop out0");
        drive(0, 0, 16'h0, 0, 0);
        chk("t1_del0", {16'd0, del0}, 32'd1);
        chk("t1_occ0b", {30'd0, occ0}, 32'd0);

        // Stalled output 1 does not block output 0
        drive(1, 1, 16'hA001, 0, 0); step(); $display("TX push sel=1 data=A001");
        drive(1, 1, 16'hA002, 0, 0); step(); $display("TX push sel=1 data=A002");
        drive(1, 1, 16'hA003, 0, 0);
        chk("t2_occ1", {30'd0, occ1}, 32'd2);
        chk("t2_rdy_full1", {31'd0, in_ready}, 32'd0);
        step();
        drive(1, 0, 16'hB000, 0, 0);
        chk("t2_rdy_sel0", {31'd0, in_ready}, 32'd1);
        step(); $display("TX push sel=0 data=B000");
        drive(0, 0, 16'h0, 0, 1);
        chk("t2_data0", {16'd0, out0_data}, 32'hB000);
        chk("t2_head1", {16'd0, out1_data}, 32'hA001);
        step(); $display("TX pop out1 A001");
        chk("t2_head1b", {16'd0, out1_data}, 32'hA002);
        step(); $display("TX pop out1 A002");
        chk("t2_del1", {16'd0, del1}, 32'd2);
        chk("t2_occ1b", {30'd0, occ1}, 32'd0);
        drive(0, 0, 16'h0, 1, 0);
        step(); $display("TX pop out0 B000");

        // Full FIFO 0 with a same-cycle pop: no refill that cycle
        drive(1, 0, 16'hC001, 0, 0); step(); $display("TX push sel=0 data=C001");
        drive(1, 0, 16'hC002, 0, 0); step(); $display("TX push sel=0 data=C002");
        drive(1, 0, 16'hC003, 1, 0);
        chk("t3_rdy_full", {31'd0, in_ready}, 32'd0);
        step(); $display("TX pop out0 C001, push refused");
        chk("t3_occ0", {30'd0, occ0}, 32'd1);
        chk("t3_head0", {16'd0, out0_data}, 32'hC002);
        drive(1, 0, 16'hC003, 0, 0);
        chk("t3_rdy_again", {31'd0, in_ready}, 32'd1);
        step(); $display("TX push sel=0 data=C003");
        chk("t3_occ0b", {30'd0, occ0}, 32'd2);

        // Half-full FIFO 0 with simultaneous push and pop
        drive(0, 0, 16'h0, 1, 0); step(); $display("TX pop out0 C002");
        drive(1, 0, 16'h0055, 1, 0); step(); $display("TX push 0055 + pop C003");
        chk("t4_occ0", {30'd0, occ0}, 32'd1);
        chk("t4_head0", {16'd0, out0_data}, 32'h0055);
        drive(0, 0, 16'h0, 1, 0); step(); $display("TX pop out0 0055");
        chk("t4_del0", {16'd0, del0}, 32'd6);

        // Alternating select, both outputs draining
        for (int i = 0; i < 8; i++) begin
            drive(1, 1'(i % 2), 16'(i), 1, 1);
            step();
            $display("TX push sel=%0d data=%04h", i % 2, i);
            if (i % 2 == 0) chk("t5_data0", {16'd0, out0_data}, 32'(i));
            else            chk("t5_data1", {16'd0, out1_data}, 32'(i));
        end
        drive(0, 0, 16'h0, 1, 1);
        step();
        chk("t5_del0", {16'd0, del0}, 32'd10);
        chk("t5_del1", {16'd0, del1}, 32'd6);

        // Run del0 up to 0xFFFE (65524 more pops), then wrap it
        $display("TX bulk stream of 65524 words to out0");
        for (int n = 0; n < 65524; n++) begin
            drive(1, 0, 16'(n), 1, 0);
            step();
        end
        drive(0, 0, 16'h0, 1, 0);
        step();
        chk("t6_del0_fffe", {16'd0, del0}, 32'hFFFE);
        drive(1, 0, 16'hD001, 0, 0); step(); $display("TX push sel=0 data=D001");
        drive(1, 0, 16'hD002, 0, 0); step(); $display("TX push sel=0 data=D002");
        drive(0, 0, 16'h0, 1, 0);
        step(); $display("TX pop out0 D001");
        chk("t6_del0_ffff", {16'd0, del0}, 32'hFFFF);
        step(); $display("TX pop out0 D002");
        chk("t6_del0_wrap", {16'd0, del0}, 32'h0000);
        chk("t6_occ0", {30'd0, occ0}, 32'd0);

        // Reset with FIFO 0 full and del0 non-zero
        drive(1, 0, 16'hE001, 0, 0); step(); $display("TX push sel=0 data=E001");
        drive(1, 0, 16'hE002, 0, 0); step(); $display("TX push sel=0 data=E002");
        drive(0, 0, 16'h0, 1, 0);    step(); $display("TX pop out0 E001");
        drive(1, 0, 16'hE003, 0, 0); step(); $display("TX push sel=0 data=E003");
        chk("t7_pre_occ0", {30'd0, occ0}, 32'd2);
        chk("t7_pre_del0", {16'd0, del0}, 32'd1);
        rst_n = 1'b0;
        drive(1, 0, 16'hE004, 1, 1);
        step(); $display("TX reset with handshakes pending");
        rst_n = 1'b1;
        drive(0, 0, 16'h0, 0, 0);
        chk("t7_occ0",   {30'd0, occ0}, 32'd0);
        chk("t7_valid0", {31'd0, out0_valid}, 32'd0);
        chk("t7_data0",  {16'd0, out0_data}, 32'd0);
        chk("t7_data1",  {16'd0, out1_data}, 32'd0);
        chk("t7_del0",   {16'd0, del0}, 32'd0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_demux_stream.md
Name: data_demux_stream

Overview:
- Stream demultiplexer, the inverse of the 2:1 data mux. It accepts one WIDTH-bit input stream with a per-word select and routes each word to one of two output streams.
- All three streams use valid/ready handshakes.
- Each output has its own DEPTH-entry FIFO, so a stalled output does not block traffic to the other output unless the next input word targets the stalled one.
- The block sits between a single producer (datapath result bus) and two consumers.

Parameters:
- WIDTH, 16, data width of all streams.
- DEPTH, 2, entries per output FIFO; must be a power of 2, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  WIDTH  input word.
- in_sel  input  1  destination of in_data: 0 selects output 0, 1 selects output 1.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block accepts the word this cycle.
- out0_data  output  WIDTH  head word of FIFO 0.
- out0_valid  output  1  FIFO 0 non-empty.
- out0_ready  input  1  consumer 0 takes the head word.
- out1_data  output  WIDTH  head word of FIFO 1.
- out1_valid  output  1  FIFO 1 non-empty.
- out1_ready  input  1  consumer 1 takes the head word.
- occ0  output  $clog2(DEPTH)+1  FIFO 0 occupancy.
- occ1  output  $clog2(DEPTH)+1  FIFO 1 occupancy.
- del0  output  16  count of words delivered on output 0; wraps.
- del1  output  16  count of words delivered on output 1; wraps.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - occ0, occ1, del0 and del1 go to 0.
  - Read/write pointers go to 0.
  - All FIFO storage clears to 0.
  - out0_valid and out1_valid are 0; out0_data and out1_data read 0.
  - Reset mid-operation discards all buffered words; in-flight handshakes that cycle are ignored.
- Input handshake:
  - in_ready = (in_sel ? !full1 : !full0), where fullN = (occN==DEPTH).
  - in_ready is combinational from in_sel and registered occupancy only. There is no path from out*_ready to in_ready.
  - Accept = in_valid && in_ready. On accept, in_data is written to FIFO[in_sel] at its write pointer, and that write pointer increments modulo DEPTH.
  - in_ready may be low while in_valid is low. The producer must hold in_data and in_sel stable until accept.
- Output handshake:
  - outN_valid = (occN != 0).
  - outN_data = FIFO N entry at its read pointer. The value is don't-care while outN_valid=0 after first use.
  - Pop = outN_valid && outN_ready. On pop the read pointer increments modulo DEPTH and delN increments by 1 (0xFFFF -> 0x0000).
- Latency: a word accepted at edge k appears on outN_valid/outN_data immediately after edge k (1 cycle). Zero-cycle pass-through is not supported.
- Occupancy update per FIFO per edge: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full FIFO with pop in the same cycle: in_ready is still 0 for that destination (decided; no same-cycle refill). One bubble results.
- Ordering: order is preserved within each output. No ordering guarantee across outputs.
- Head-of-line rule: if the current input word targets a full FIFO, in_ready=0 even if the other FIFO has space. The input is never reordered.
- Pointer wrap: pointers are $clog2(DEPTH) bits wide; full/empty are determined from occN, not from pointer comparison.
- Outputs 0 and 1 are fully independent except for sharing the input port.

Test Plan:
- Reset, then in_valid=1, in_sel=0, in_data=0x1234 for one cycle with out0_ready=0 -> next cycle out0_valid=1, out0_data=0x1234, occ0=1; out1_valid=0; after out0_ready=1 for one cycle, del0=1 and occ0=0.
- With out1_ready=0, push 0xA001, 0xA002 to sel=1 -> occ1=2 and in_ready=0 for sel=1. Present 0xB000 with sel=0 while holding the stall -> in_ready=1 and it reaches out0. Release out1_ready -> 0xA001 then 0xA002 delivered in order, del1=2.
- FIFO 0 full (DEPTH=2), same-cycle in_valid with sel=0 and out0_ready=1 -> in_ready=0 that cycle, occ0 becomes 1. The next cycle the push is accepted and occ0 becomes 2.
- Half-full FIFO 0 with simultaneous push 0x0055 and pop -> occ0 stays 1, and the head advances to the older word's successor.
- Alternate sel every cycle for 8 words 0x0000..0x0007 with both readies high -> out0 receives the even values and out1 the odd values in order; del0=del1=4.
- Preload del0=0xFFFE (run 65534 pops), pop twice -> del0 wraps to 0x0000. Assert rst_n=0 with occ0=2 -> next edge occ0=0, out0_valid=0, out0_data=0, del0=0.
